input_value_reader: RTL and testbench

INPUT_VALUE_READER -- requirements
Module: input_value_reader

---
 rtl/snn_pkg.sv | 16 +
 rtl/skid_fifo2.sv | 73 +++++++
 rtl/input_value_reader.sv | 106 ++++++++++
 tb/tb_input_value_reader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared FSM encoding and default constants for the SNN input path
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  localparam int DEF_INPUT_NEURON_NUM = 1023;
  localparam int DEF_ADDR_W           = 10;
  localparam int DEF_DATA_W           = 8;
  localparam int FIFO_DEPTH           = 2;

endpackage

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - two-entry output buffer; head register drives the beat directly
module skid_fifo2
  import snn_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         push, pop;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign count     = count_q;
  assign pop       = out_valid && pop_ready;
  assign push      = push_valid && ((count_q != 2'(FIFO_DEPTH)) || pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          // Occupancy unchanged; head only moves when a second entry is waiting.
          if (count_q == 2'd1) begin
            head_d = push_data;
          end else begin
            head_d = tail_q;
            tail_d = push_data;
          end
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) head_d = push_data;
          else                 tail_d = push_data;
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/input_value_reader.sv
// rtl/input_value_reader.sv - scans the input-value memory and streams {addr, data} beats
module input_value_reader
  import snn_pkg::*;
#(
  parameter int INPUT_NEURON_NUM = DEF_INPUT_NEURON_NUM,
  parameter int ADDR_W           = DEF_ADDR_W,
  parameter int DATA_W           = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              skip_zero,
  input  logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(INPUT_NEURON_NUM - 1);

  rd_state_t                state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d, rd_addr_q, rd_addr_d;
  logic                     skip_q, skip_d, inflight_q, inflight_d;
  logic                     flush, push, pop, issue;
  logic [1:0]               occ;
  logic [2:0]               load;
  logic [ADDR_W+DATA_W-1:0] fifo_dout;

  assign pop  = out_valid && out_ready;
  assign push = inflight_q && !(skip_q && (mem_data_out == '0));
  // Next-cycle occupancy; a dropped zero never counts, so its credit is free at once.
  assign load  = {1'b0, occ} + {2'b0, push} - {2'b0, pop};
  assign issue = (state_q == ST_RUN) && !mem_wr_en && (load < 3'd2);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_addr_d  = rd_addr_q;
    skip_d     = skip_q;
    inflight_d = issue;
    flush      = 1'b0;
    if (issue) rd_addr_d = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          addr_d     = '0;
          skip_d     = skip_zero;
          inflight_d = 1'b0;
          flush      = 1'b1;
        end
      end
      ST_RUN: begin
        if (issue) begin
          if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
          else                     addr_d  = addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && (occ == 2'd0)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rd_addr_q  <= '0;
      skip_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_addr_q  <= rd_addr_d;
      skip_q     <= skip_d;
      inflight_q <= inflight_d;
    end
  end

  skid_fifo2 #(.W(ADDR_W + DATA_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (push),
    .push_data  ({rd_addr_q, mem_data_out}),
    .pop_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (fifo_dout),
    .count      (occ)
  );

  assign out_addr     = fifo_dout[ADDR_W+DATA_W-1:DATA_W];
  assign out_data     = fifo_dout[DATA_W-1:0];
  assign mem_addr_out = addr_q;
  assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_input_value_reader.sv
// tb/tb_input_value_reader.sv - directed self-checking bench for input_value_reader
module tb_input_value_reader;

  logic       clk = 1'b0;
  logic       rst_n, start, skip_zero, mem_wr_en, out_ready;
  logic [9:0] mem_addr_out, out_addr;
  logic [7:0] mem_data_out, out_data;
  logic       out_valid, busy, done;

  logic [7:0] mem [0:1023];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         start_cyc;
  bit         timed_out;

  logic [9:0] got_addr[$];
  logic [7:0] got_data[$];
  int         got_cyc[$];
  int         done_cnt, done_cyc, first_valid_cyc, stall_err;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_addr;
  logic [7:0] prev_data;

  input_value_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .skip_zero    (skip_zero),
    .mem_wr_en    (mem_wr_en),
    .mem_addr_out (mem_addr_out),
    .mem_data_out (mem_data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Memory model: one-cycle read latency, read port frozen during writes.
  always @(posedge clk) if (!mem_wr_en) mem_data_out <= mem[mem_addr_out];

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_addr.push_back(out_addr);
      got_data.push_back(out_data);
      got_cyc.push_back(cyc);
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_stall && rst_n && (!out_valid || out_addr !== prev_addr || out_data !== prev_data))
      stall_err++;
    prev_stall = rst_n && out_valid && !out_ready;
    prev_addr  = out_addr;
    prev_data  = out_data;
  end

  task automatic clear_rec();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    first_valid_cyc = -1;
    stall_err = 0;
  endtask

  task automatic do_start(input logic skip);
    @(posedge clk); #1;
    start     = 1'b1;
    skip_zero = skip;
    start_cyc = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic run_scan(input int limit, input int ready_pct, input int wr_addr, input int restart_at);
    int wr_left = 0;
    int tail = -1;
    timed_out = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      out_ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < ready_pct);
      start = (i == restart_at);
      if (wr_left > 0) wr_left--;
      else if (wr_addr >= 0 && busy && mem_addr_out == 10'(wr_addr)) begin
        wr_left = 3;
        wr_addr = -1;
      end
      mem_wr_en = (wr_left > 0);
      if (done_cnt > 0 && tail < 0) tail = 4;
      if (tail > 0) tail--;
      if (tail == 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    mem_wr_en = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (mem_addr_out !== 10'd0) begin $display("FAIL rst_mem_addr: got %0d want 0", mem_addr_out); bad++; end
    total++; if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid: got %b want 0", out_valid); bad++; end
    total++; if (out_addr !== 10'd0) begin $display("FAIL rst_out_addr: got %0d want 0", out_addr); bad++; end
    total++; if (out_data !== 8'd0) begin $display("FAIL rst_out_data: got %0d want 0", out_data); bad++; end
    total++; if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy); bad++; end
    total++; if (done !== 1'b0) begin $display("FAIL rst_done: got %b want 0", done); bad++; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin $display("FAIL idle_no_start: got busy=%b valid=%b want 0 0", busy, out_valid); bad++; end
  endtask

  task automatic test_full_scan();
    int err_i = -1;
    int n;
    for (int a = 0; a < 1024; a++) mem[a] = 8'(a);
    out_ready = 1'b1;
    clear_rec();
    do_start(1'b0);
    run_scan(3000, 100, -1, -1);
    n = got_addr.size();
    total++; if (timed_out) begin $display("FAIL full_timeout: got no done want done"); bad++; end
    total++; if (n !== 1023) begin $display("FAIL full_count: got %0d want 1023", n); bad++; end
    total++;
    foreach (got_addr[i]) if (err_i < 0 && (got_addr[i] !== 10'(i) || got_data[i] !== 8'(i % 256))) err_i = i;
    if (err_i >= 0) begin
      $display("FAIL full_beat[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
               err_i, got_addr[err_i], got_data[err_i], err_i, err_i % 256);
      bad++;
    end
    total++; if (first_valid_cyc < 0 || first_valid_cyc - start_cyc > 3) begin $display("FAIL full_latency: got %0d want <=3", first_valid_cyc - start_cyc); bad++; end
    if (n > 0) begin
      total++; if (got_cyc[n-1] - got_cyc[0] !== 1022) begin $display("FAIL full_rate: got span %0d want 1022", got_cyc[n-1] - got_cyc[0]); bad++; end
      total++; if (done_cyc <= got_cyc[n-1]) begin $display("FAIL full_done_order: got done cyc %0d want > %0d", done_cyc, got_cyc[n-1]); bad++; end
    end
    total++; if (done_cnt !== 1) begin $display("FAIL full_done_cnt: got %0d want 1", done_cnt); bad++; end
  endtask

  task automatic test_skip_zero();
    int err_i = -1;
    for (int a = 0; a < 1024; a++) mem[a] = (a % 2 == 1) ? 8'd5 : 8'd0;
    clear_rec();
    do_start(1'b1);
    run_scan(3000, 100, -1, -1);
    total++; if (timed_out) begin $display("FAIL skip_timeout: got no done want done"); bad++; end
    total++; if (got_addr.size() !== 511) begin $display("FAIL skip_count: got %0d want 511", got_addr.size()); bad++; end
    total++;
    foreach (got_addr[i]) if (err_i < 0 && (got_addr[i] !== 10'(2*i + 1) || got_data[i] !== 8'd5)) err_i = i;
    if (err_i >= 0) begin
      $display("FAIL skip_beat[%0d]: got addr=%0d data=%0d want addr=%0d data=5",
               err_i, got_addr[err_i], got_data[err_i], 2*err_i + 1);
      bad++;
    end
    total++; if (done_cnt !== 1) begin $display("FAIL skip_done_cnt: got %0d want 1", done_cnt); bad++; end
  endtask

  task automatic test_random_ready();
    int err_i = -1;
    for (int a = 0; a < 1024; a++) mem[a] = 8'((a * 13 + 7) % 256);
    clear_rec();
    do_start(1'b0);
    run_scan(8000, 50, -1, -1);
    total++; if (timed_out) begin $display("FAIL rand_timeout: got no done want done"); bad++; end
    total++; if (got_addr.size() !== 1023) begin $display("FAIL rand_count: got %0d want 1023", got_addr.size()); bad++; end
    total++;
    foreach (got_addr[i]) if (err_i < 0 && (got_addr[i] !== 10'(i) || got_data[i] !== 8'((i * 13 + 7) % 256))) err_i = i;
    if (err_i >= 0) begin
      $display("FAIL rand_beat[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
               err_i, got_addr[err_i], got_data[err_i], err_i, (err_i * 13 + 7) % 256);
      bad++;
    end
    total++; if (stall_err !== 0) begin $display("FAIL rand_stall_stable: got %0d changes want 0", stall_err); bad++; end
    total++; if (done_cnt !== 1) begin $display("FAIL rand_done_cnt: got %0d want 1", done_cnt); bad++; end
  endtask

  task automatic test_wr_stall();
    int err_i = -1;
    int hits = 0;
    for (int a = 0; a < 1024; a++) mem[a] = 8'((a * 7 + 3) % 256);
    clear_rec();
    do_start(1'b0);
    run_scan(3000, 100, 100, -1);
    total++; if (timed_out) begin $display("FAIL wr_timeout: got no done want done"); bad++; end
    total++; if (got_addr.size() !== 1023) begin $display("FAIL wr_count: got %0d want 1023", got_addr.size()); bad++; end
    total++;
    foreach (got_addr[i]) begin
      if (got_addr[i] === 10'd100) hits++;
      if (err_i < 0 && (got_addr[i] !== 10'(i) || got_data[i] !== 8'((i * 7 + 3) % 256))) err_i = i;
    end
    if (err_i >= 0) begin
      $display("FAIL wr_beat[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
               err_i, got_addr[err_i], got_data[err_i], err_i, (err_i * 7 + 3) % 256);
      bad++;
    end
    total++; if (hits !== 1) begin $display("FAIL wr_addr100_once: got %0d want 1", hits); bad++; end
  endtask

  task automatic test_reset_mid();
    int err_i = -1;
    bit reached = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = 8'(a);
    clear_rec();
    do_start(1'b0);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (got_addr.size() >= 400) begin
        reached = 1'b1;
        break;
      end
    end
    total++; if (!reached) begin $display("FAIL mid_reach400: got %0d beats want 400", got_addr.size()); bad++; end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin $display("FAIL mid_rst_drop: got valid=%b busy=%b want 0 0", out_valid, busy); bad++; end
    total++; if (mem_addr_out !== 10'd0 || out_addr !== 10'd0) begin $display("FAIL mid_rst_addr: got mem=%0d out=%0d want 0 0", mem_addr_out, out_addr); bad++; end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    clear_rec();
    repeat (6) @(posedge clk); #1;
    total++; if (got_addr.size() !== 0 || done_cnt !== 0) begin $display("FAIL mid_quiet: got beats=%0d done=%0d want 0 0", got_addr.size(), done_cnt); bad++; end
    do_start(1'b0);
    run_scan(3000, 100, -1, -1);
    total++; if (got_addr.size() !== 1023 || done_cnt !== 1) begin $display("FAIL mid_restart: got beats=%0d done=%0d want 1023 1", got_addr.size(), done_cnt); bad++; end
    total++;
    foreach (got_addr[i]) if (err_i < 0 && (got_addr[i] !== 10'(i) || got_data[i] !== 8'(i % 256))) err_i = i;
    if (err_i >= 0) begin
      $display("FAIL mid_beat[%0d]: got addr=%0d data=%0d want addr=%0d", err_i, got_addr[err_i], got_data[err_i], err_i);
      bad++;
    end
  endtask

  task automatic test_start_ignored();
    int err_i = -1;
    for (int a = 0; a < 1024; a++) mem[a] = 8'(255 - (a % 256));
    clear_rec();
    do_start(1'b0);
    run_scan(3000, 100, -1, 200);
    total++; if (done_cnt !== 1) begin $display("FAIL restart_done_cnt: got %0d want 1", done_cnt); bad++; end
    total++; if (got_addr.size() !== 1023) begin $display("FAIL restart_count: got %0d want 1023", got_addr.size()); bad++; end
    total++;
    foreach (got_addr[i]) if (err_i < 0 && (got_addr[i] !== 10'(i) || got_data[i] !== 8'(255 - (i % 256)))) err_i = i;
    if (err_i >= 0) begin
      $display("FAIL restart_beat[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
               err_i, got_addr[err_i], got_data[err_i], err_i, 255 - (err_i % 256));
      bad++;
    end
    total++; if (busy !== 1'b0) begin $display("FAIL restart_idle: got busy=%b want 0", busy); bad++; end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    skip_zero = 1'b0;
    mem_wr_en = 1'b0;
    out_ready = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
    clear_rec();
    repeat (2) @(posedge clk);
    test_reset();
    test_full_scan();
    test_skip_zero();
    test_random_ready();
    test_wr_stall();
    test_reset_mid();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
